// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the N-wide in-order issue scoreboard.
package scoreboard_pkg;

    localparam int FWD_NONE     = 0;
    localparam int LOAD_LAT_DEF = 2;
    localparam int ALU_LAT_DEF  = 1;
    localparam int REG_MAX_W    = 8;

    // Register fields are sized for the widest supported register file and zero-extended.
    typedef struct packed {
        logic [REG_MAX_W-1:0] rs1;
        logic [REG_MAX_W-1:0] rs2;
        logic [REG_MAX_W-1:0] rd;
        logic                 wb;
        logic                 load;
        logic                 use_rs2;
    } slot_t;

    function automatic int fwd_sel_w(input int issue_w);
        return $clog2(issue_w) + 1;
    endfunction

endpackage

// File: rtl/sb_reg_counter.sv
// Per-register pending-write countdown: load overrides decrement, async clear on reset.
module sb_reg_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [CNT_W-1:0] set_val,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (set) begin
            count <= set_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// N-wide in-order issue scoreboard with intra-group forwarding selects.
// Optional stall perf counter built only when SB_PERF_EN is defined.
module issue_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int ISSUE_W  = 2,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int ALU_LAT  = ALU_LAT_DEF,
    parameter int CNT_W    = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ISSUE_W-1:0]                    in_valid,
    input  logic [ISSUE_W*REG_W-1:0]              in_rs1,
    input  logic [ISSUE_W*REG_W-1:0]              in_rs2,
    input  logic [ISSUE_W*REG_W-1:0]              in_rd,
    input  logic [ISSUE_W-1:0]                    in_wb,
    input  logic [ISSUE_W-1:0]                    in_load,
    input  logic [ISSUE_W-1:0]                    in_use_rs2,
    input  logic                                  flush,
    output logic [ISSUE_W-1:0]                    issue_mask,
    output logic [ISSUE_W*($clog2(ISSUE_W)+1)-1:0] fwd_src1,
    output logic [ISSUE_W*($clog2(ISSUE_W)+1)-1:0] fwd_src2,
    output logic [31:0]                           stall_cycles
);

    localparam int FW       = fwd_sel_w(ISSUE_W);
    localparam int NREG_IDX = 1 << REG_W;
    localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] ALU_SET  = CNT_W'(ALU_LAT - 1);

    slot_t               slot [ISSUE_W];
    logic [NREG_IDX-1:0] blocked;
    logic [ISSUE_W-1:0]  eligible;
    logic [ISSUE_W-1:0]  wr_en;
    logic [FW-1:0]       src1_sel [ISSUE_W];
    logic [FW-1:0]       src2_sel [ISSUE_W];
    logic                chain;

    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            slot[i].rs1     = REG_MAX_W'(in_rs1[i*REG_W +: REG_W]);
            slot[i].rs2     = REG_MAX_W'(in_rs2[i*REG_W +: REG_W]);
            slot[i].rd      = REG_MAX_W'(in_rd[i*REG_W +: REG_W]);
            slot[i].wb      = in_wb[i];
            slot[i].load    = in_load[i];
            slot[i].use_rs2 = in_use_rs2[i];
        end
    end

    // Scan older slots in age order so the youngest matching producer wins the forward select.
    always_comb begin
        for (int i = 0; i < ISSUE_W; i++) begin
            eligible[i] = in_valid[i]
                        & ~blocked[slot[i].rs1[REG_W-1:0]]
                        & ~(slot[i].use_rs2 & blocked[slot[i].rs2[REG_W-1:0]]);
            src1_sel[i] = FW'(FWD_NONE);
            src2_sel[i] = FW'(FWD_NONE);
            for (int j = 0; j < i; j++) begin
                if (slot[j].wb && slot[j].rd != '0) begin
                    if (slot[j].rd == slot[i].rs1) begin
                        src1_sel[i] = FW'(j + 1);
                        if (slot[j].load) eligible[i] = 1'b0;
                    end
                    if (slot[i].use_rs2 && slot[j].rd == slot[i].rs2) begin
                        src2_sel[i] = FW'(j + 1);
                        if (slot[j].load) eligible[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        chain = rst_n & ~flush;
        for (int i = 0; i < ISSUE_W; i++) begin
            issue_mask[i] = chain & eligible[i];
            chain         = issue_mask[i];
        end
    end

    always_comb begin
        fwd_src1 = '0;
        fwd_src2 = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            wr_en[i] = issue_mask[i] & slot[i].wb & (slot[i].rd != '0);
            if (issue_mask[i]) begin
                fwd_src1[i*FW +: FW] = src1_sel[i];
                fwd_src2[i*FW +: FW] = src2_sel[i];
            end
        end
    end

    // Index space is padded to a power of two; x0 and out-of-range indices are never pending.
    for (genvar r = 0; r < NREG_IDX; r++) begin : g_reg
        if (r == 0 || r >= NUM_REGS) begin : g_none
            assign blocked[r] = 1'b0;
        end else begin : g_cnt
            logic             set;
            logic [CNT_W-1:0] set_val;
            logic [CNT_W-1:0] count;

            always_comb begin
                set     = 1'b0;
                set_val = ALU_SET;
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (wr_en[i] && slot[i].rd == REG_MAX_W'(r)) begin
                        set     = 1'b1;
                        set_val = slot[i].load ? LOAD_SET : ALU_SET;
                    end
                end
            end

            sb_reg_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .set     (set),
                .set_val (set_val),
                .count   (count)
            );

            assign blocked[r] = |count;
        end
    end

`ifdef SB_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!flush && in_valid[0] && !issue_mask[0] && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed table-driven bench for issue_scoreboard (2-wide; LOAD_LAT=2 and LOAD_LAT=3 instances).
module tb_issue_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid, wb, ld, use2;
    logic [9:0]  rs1, rs2, rd;
    logic        flush;
    logic [1:0]  mask;
    logic [3:0]  f1, f2;
    logic [31:0] stall;

    logic [1:0]  t3_valid, t3_wb, t3_ld, t3_use2;
    logic [9:0]  t3_rs1, t3_rs2, t3_rd;
    logic        t3_flush;
    logic [1:0]  t3_mask;
    logic [3:0]  t3_f1, t3_f2;
    logic [31:0] t3_stall;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    issue_scoreboard #(.ISSUE_W(2), .LOAD_LAT(2), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(valid), .in_rs1(rs1), .in_rs2(rs2), .in_rd(rd),
        .in_wb(wb), .in_load(ld), .in_use_rs2(use2), .flush(flush),
        .issue_mask(mask), .fwd_src1(f1), .fwd_src2(f2), .stall_cycles(stall)
    );

    issue_scoreboard #(.ISSUE_W(2), .LOAD_LAT(3), .ALU_LAT(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(t3_valid), .in_rs1(t3_rs1), .in_rs2(t3_rs2), .in_rd(t3_rd),
        .in_wb(t3_wb), .in_load(t3_ld), .in_use_rs2(t3_use2), .flush(t3_flush),
        .issue_mask(t3_mask), .fwd_src1(t3_f1), .fwd_src2(t3_f2), .stall_cycles(t3_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [9:0] rs1, rs2, rd;
        logic [1:0] wb, ld, use2;
        logic       flush;
        logic [1:0] mask;
        logic [3:0] f1, f2;
    } vec_t;

    vec_t vecs [15];

    // Pack slot0 register a and slot1 register b.
    function automatic logic [9:0] r2(input int a, input int b);
        return {b[4:0], a[4:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        valid = v.valid; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
        wb = v.wb; ld = v.ld; use2 = v.use2; flush = v.flush;
    endtask

    initial begin
        //              name             valid  rs1        rs2        rd          wb     ld     use2   fl  mask   f1       f2
        vecs[0]  = '{"alu_pair",       2'b11, r2(3,5),   r2(4,6),   r2(1,2),   2'b11, 2'b00, 2'b11, 0, 2'b11, 4'b0000, 4'b0000};
        vecs[1]  = '{"alu_fwd_rs2",    2'b11, r2(1,8),   r2(2,7),   r2(7,10),  2'b11, 2'b00, 2'b11, 0, 2'b11, 4'b0000, 4'b0100};
        vecs[2]  = '{"ld_use_group",   2'b11, r2(3,5),   r2(0,0),   r2(5,11),  2'b11, 2'b01, 2'b00, 0, 2'b01, 4'b0000, 4'b0000};
        vecs[3]  = '{"ld_use_bubble",  2'b11, r2(5,0),   r2(0,0),   r2(12,13), 2'b11, 2'b00, 2'b00, 0, 2'b00, 4'b0000, 4'b0000};
        vecs[4]  = '{"ld_use_issue",   2'b11, r2(5,0),   r2(0,0),   r2(12,13), 2'b11, 2'b00, 2'b00, 0, 2'b11, 4'b0000, 4'b0000};
        vecs[5]  = '{"ld_x0",          2'b11, r2(3,0),   r2(0,0),   r2(0,14),  2'b11, 2'b01, 2'b10, 0, 2'b11, 4'b0000, 4'b0000};
        vecs[6]  = '{"x0_consumer",    2'b01, r2(0,0),   r2(0,0),   r2(15,0),  2'b01, 2'b00, 2'b00, 0, 2'b01, 4'b0000, 4'b0000};
        vecs[7]  = '{"alu_waw_fwd",    2'b11, r2(3,20),  r2(0,0),   r2(20,20), 2'b11, 2'b00, 2'b00, 0, 2'b11, 4'b0100, 4'b0000};
        vecs[8]  = '{"ld_pending",     2'b01, r2(3,0),   r2(0,0),   r2(21,0),  2'b01, 2'b01, 2'b00, 0, 2'b01, 4'b0000, 4'b0000};
        vecs[9]  = '{"flush",          2'b11, r2(3,4),   r2(0,0),   r2(22,23), 2'b11, 2'b00, 2'b00, 1, 2'b00, 4'b0000, 4'b0000};
        vecs[10] = '{"after_flush",    2'b01, r2(21,0),  r2(0,0),   r2(26,0),  2'b01, 2'b00, 2'b00, 0, 2'b01, 4'b0000, 4'b0000};
        vecs[11] = '{"rs2_load_block", 2'b11, r2(3,3),   r2(0,24),  r2(24,27), 2'b11, 2'b01, 2'b10, 0, 2'b01, 4'b0000, 4'b0000};
        vecs[12] = '{"rs2_unused",     2'b11, r2(3,3),   r2(0,25),  r2(25,28), 2'b11, 2'b01, 2'b00, 0, 2'b11, 4'b0000, 4'b0000};
        vecs[13] = '{"slot0_invalid",  2'b10, r2(3,3),   r2(0,0),   r2(0,29),  2'b10, 2'b00, 2'b00, 0, 2'b00, 4'b0000, 4'b0000};
        vecs[14] = '{"no_wb_match",    2'b11, r2(3,30),  r2(0,0),   r2(30,31), 2'b10, 2'b01, 2'b00, 0, 2'b11, 4'b0000, 4'b0000};

        t3_valid = '0; t3_wb = '0; t3_ld = '0; t3_use2 = '0;
        t3_rs1 = '0; t3_rs2 = '0; t3_rd = '0; t3_flush = 1'b0;

        // Inputs that would issue and forward if reset were not forcing outputs low.
        rst_n = 1'b0; flush = 1'b0;
        valid = 2'b11; rs1 = r2(3,1); rs2 = r2(4,1); rd = r2(1,2);
        wb = 2'b11; ld = 2'b00; use2 = 2'b11;
        #2;
        chk("reset_mask",  32'(mask), 32'h0);
        chk("reset_f1",    32'(f1),   32'h0);
        chk("reset_f2",    32'(f2),   32'h0);
        chk("reset_stall", stall,     32'h0);
        chk("reset_stall3", t3_stall, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            apply(vecs[k]);
            #1;
            chk({vecs[k].name, "_mask"}, 32'(mask), 32'(vecs[k].mask));
            chk({vecs[k].name, "_f1"},   32'(f1),   32'(vecs[k].f1));
            chk({vecs[k].name, "_f2"},   32'(f2),   32'(vecs[k].f2));
        end

        @(negedge clk);
        valid = 2'b00;
        #1;
        chk("stall_count", stall, PERF ? 32'd1 : 32'd0);

        // LOAD_LAT=3: consumer held from the cycle after the load issues.
        @(negedge clk);
        t3_valid = 2'b01; t3_rs1 = r2(3,0); t3_rd = r2(9,0); t3_wb = 2'b01; t3_ld = 2'b01;
        #1; chk("lat3_load_issue", 32'(t3_mask), 32'h1);
        @(negedge clk);
        t3_rs1 = r2(9,0); t3_rd = r2(10,0); t3_ld = 2'b00;
        #1; chk("lat3_block_n1", 32'(t3_mask), 32'h0);
        @(negedge clk);
        #1; chk("lat3_block_n2", 32'(t3_mask), 32'h0);
        @(negedge clk);
        #1; chk("lat3_issue_n3", 32'(t3_mask), 32'h1);
        chk("lat3_f1", 32'(t3_f1), 32'h0);
        @(negedge clk);
        t3_valid = 2'b00;
        #1; chk("lat3_stall_count", t3_stall, PERF ? 32'd2 : 32'd0);

        // Asynchronous reset mid-operation clears a pending load counter at once.
        @(negedge clk);
        valid = 2'b01; rs1 = r2(3,0); rs2 = r2(0,0); rd = r2(5,0);
        wb = 2'b01; ld = 2'b01; use2 = 2'b00; flush = 1'b0;
        #1; chk("mid_load_issue", 32'(mask), 32'h1);
        @(negedge clk);
        rs1 = r2(5,0); rd = r2(6,0); ld = 2'b00;
        #1; chk("mid_blocked", 32'(mask), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_mask",  32'(mask), 32'h0);
        chk("mid_reset_stall", stall,     32'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_after_reset_mask", 32'(mask), 32'h1);
        chk("mid_after_reset_f1",   32'(f1),   32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
